// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead add/subtract unit.
package cla_pkg;

    localparam int GRP_W = 4;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead group: flat two-level carry equations
// so c4 never ripples through c1..c3.
module cla4_slice
    import cla_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             c0,
    output logic [GRP_W-1:0] s,
    output logic             c3,
    output logic             c4
);

    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] p;
    logic             c1;
    logic             c2;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c0);
        s  = p ^ {c3, c2, c1, c0};
    end

endmodule

// File: rtl/cla_seq_addsub.sv
// Multi-cycle add/subtract: one 4-bit lookahead group per cycle, LSB first,
// with a start/busy/done handshake and registered result/co/ovf.
module cla_seq_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             ovf
);

    localparam int              NGRP     = WIDTH / GRP_W;
    localparam int              CW       = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [CW-1:0]   LAST_GRP = CW'(NGRP - 1);

    state_t           state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_q,      c_d;
    logic             sub_q,    sub_d;
    logic             co_q,     co_d;
    logic             ovf_q,    ovf_d;
    logic             done_q,   done_d;

    logic [GRP_W-1:0] slice_s;
    logic             slice_c3;
    logic             slice_c4;
    logic [WIDTH-1:0] s_ext;

    cla4_slice u_slice (
        .a  (a_q[GRP_W-1:0]),
        .b  (b_q[GRP_W-1:0]),
        .c0 (c_q),
        .s  (slice_s),
        .c3 (slice_c3),
        .c4 (slice_c4)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        c_d      = c_q;
        sub_d    = sub_q;
        co_d     = co_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        s_ext    = '0;
        s_ext[WIDTH-1 -: GRP_W] = slice_s;

        case (state_q)
            IDLE: begin
                // Subtraction is a + ~b + ~borrow, so only B and the carry are inverted.
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub ? ~cin : cin;
                    sub_d   = sub;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> GRP_W;
                b_d   = b_q >> GRP_W;
                acc_d = (acc_q >> GRP_W) | s_ext;
                c_d   = slice_c4;
                if (cnt_q == LAST_GRP) begin
                    result_d = acc_d;
                    co_d     = sub_q ^ slice_c4;
                    ovf_d    = slice_c3 ^ slice_c4;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            c_q      <= 1'b0;
            sub_q    <= 1'b0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            c_q      <= c_d;
            sub_q    <= sub_d;
            co_q     <= co_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign result = result_q;
    assign co     = co_q;
    assign ovf    = ovf_q;

endmodule
